ex_muldiv: RTL and testbench

Iterative multiply/divide unit at the reader end of the ID/EX pipeline register. It sits in the EX stage and consumes the latched operands (RD1, RD2) together with a decoded mul/div opcode. It computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over 33 cycles, and also services MTHI/MTLO. It raises a busy flag, which the hazard unit uses to stall any later MFHI/MFLO or mul/div issue.

---
 rtl/ex_muldiv_if.sv | 17 +
 rtl/ex_muldiv.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between EX control and the iterative mul/div unit.
// Covers the start request, opcode, operands, HI/LO and the busy/done status.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, rd1, rd2, input hi, lo, busy, done);
  modport slave  (input start, op, rd1, rd2, output hi, lo, busy, done);
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Each operation runs on magnitudes for WIDTH cycles, then a sign fix-up cycle writes HI/LO.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_next;
  logic [5:0]         cnt, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q, neg_r, is_div;
  logic               is_signed, is_mul_op, is_div_op, div_zero;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  assign is_signed = ~bus.op[0];
  assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign div_zero  = (bus.rd2 == '0);

  // Multiply step: low half holds the remaining multiplier bits, upper half the partial product.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  // Restoring divide step: upper half is the remainder, lower half shifts dividend out / quotient in.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && is_mul_op) begin
          state_next = MUL;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end else if (bus.start && is_div_op) begin
          state_next = DIV;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end
      MUL, DIV: begin
        cnt_next = cnt + 6'd1;
        if (cnt == 6'(WIDTH-1)) begin
          state_next = FIX;
          cnt_next   = '0;
        end
      end
      FIX: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // HI/LO are architectural and must clear on reset; the working registers need not.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) hi_reg <= bus.rd1;
            if (bus.op == OP_MTLO) lo_reg <= bus.rd1;
          end
        end
        FIX: begin
          if (is_div) begin
            lo_reg <= neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            hi_reg <= neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi_reg, lo_reg} <= neg_q ? neg_2w(acc) : acc;
          end
        end
        default: ;
      endcase
    end
  end

  // A zero divisor keeps the raw dividend and clear signs, so the step naturally yields HI=rd1, LO=~0.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start && is_mul_op) begin
          opnd   <= mag(bus.rd1, is_signed);
          acc    <= {{WIDTH{1'b0}}, mag(bus.rd2, is_signed)};
          neg_q  <= is_signed & (bus.rd1[WIDTH-1] ^ bus.rd2[WIDTH-1]);
          neg_r  <= 1'b0;
          is_div <= 1'b0;
        end else if (bus.start && is_div_op) begin
          opnd   <= mag(bus.rd2, is_signed);
          acc    <= {{WIDTH{1'b0}}, (div_zero ? bus.rd1 : mag(bus.rd1, is_signed))};
          neg_q  <= is_signed & ~div_zero & (bus.rd1[WIDTH-1] ^ bus.rd2[WIDTH-1]);
          neg_r  <= is_signed & ~div_zero & bus.rd1[WIDTH-1];
          is_div <= 1'b1;
        end
      end
      MUL: acc <= {mul_sum, acc[WIDTH-1:1]};
      DIV: acc <= {div_rem, acc[WIDTH-2:0], div_ge};
      default: ;
    endcase
  end

  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: table of mul/div vectors with latency checks,
// plus hand sequences for busy-ignore, MTxx, no-op opcodes and mid-operation reset.
module tb_ex_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(W)) bus ();
  ex_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; starts an op at the next posedge (E0), follows it to DONE and returns
  // at the negedge where DONE is seen. With inject set, fires an MTHI and a DIV while busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input bit inject);
    int nb;
    bit seen;
    bit held;
    logic [W-1:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.rd1 = a; bus.rd2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_done_low_after_start"}, {31'd0, bus.done}, 32'd0);
    nb = 0; seen = 1'b0; held = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) nb++;
        if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
        bus.start = 1'b0;
        if (inject && k == 5) begin
          bus.start = 1'b1; bus.op = 3'b100; bus.rd1 = 32'h1234; bus.rd2 = 32'd0;
        end else if (inject && k == 10) begin
          bus.start = 1'b1; bus.op = 3'b010; bus.rd1 = 32'd9; bus.rd2 = 32'd3;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_busy_cycles"}, nb, 33);
    chk({name, "_hilo_held"}, {31'd0, held}, 32'd1);
    chk({name, "_busy_low_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    vecs[0] = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'b000, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4] = '{3'b010, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{3'b011, 32'd100,       32'd7,        32'd2,        32'd14};
    vecs[6] = '{3'b010, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{3'b011, 32'd5,         32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[8] = '{3'b010, 32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{3'b010, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.rd1 = '0; bus.rd2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    // Back-to-back: each op is issued on the edge right after the previous DONE.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);

    run_op("mult_ignore", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);

    // MTLO: one-edge latency, no busy, no done.
    bus.start = 1'b1; bus.op = 3'b101; bus.rd1 = 32'hABCD;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hABCD);
    chk("mtlo_hi_kept", bus.hi, 32'd0);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);

    bus.start = 1'b1; bus.op = 3'b100; bus.rd1 = 32'h5A5A0001;
    @(posedge clk); @(negedge clk);
    chk("mthi_hi", bus.hi, 32'h5A5A0001);
    chk("mthi_lo_kept", bus.lo, 32'hABCD);

    for (int n = 6; n < 8; n++) begin
      bus.start = 1'b1; bus.op = 3'(n); bus.rd1 = 32'hDEAD0000; bus.rd2 = 32'd3;
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("noop%0d_hi", n), bus.hi, 32'h5A5A0001);
      chk($sformatf("noop%0d_lo", n), bus.lo, 32'hABCD);
      chk($sformatf("noop%0d_busy", n), {31'd0, bus.busy}, 32'd0);
    end

    // Reset during DIVU iteration 10 aborts and clears; the first post-reset edge accepts a MULT.
    bus.start = 1'b1; bus.op = 3'b011; bus.rd1 = 32'd100; bus.rd2 = 32'd7;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    run_op("post_reset_mult", 3'b000, 32'd6, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFE8, 1'b0);

    @(negedge clk);
    chk("final_done_pulse_low", {31'd0, bus.done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
